// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches one word at a time over a
// req/ready handshake, issues it to decode and redirects on jumps/taken branches.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_eq,
   input  logic        branch_ne,
   input  logic        jump,
   input  logic        zero,
   input  logic [31:0] branch_offset,
   input  logic [25:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_plus4,
   output logic        flush
);

   typedef enum logic [1:0] {
      S_START,
      S_REQ,
      S_ISSUE
   } state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] imem_addr_next;
   logic [31:0] instr_next;
   logic [31:0] pc_plus4_next;
   logic        imem_req_next;
   logic        instr_valid_next;
   logic        flush_next;
   logic        taken;
   logic [31:0] redirect_pc;

   // Only the low 30 offset bits survive the word shift.
   logic unused_offset_msbs;
   assign unused_offset_msbs = &{1'b0, branch_offset[31:30]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_START;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr       <= 32'h0;
         instr_valid <= 1'b0;
         pc_plus4    <= 32'h0;
         flush       <= 1'b0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         imem_req    <= imem_req_next;
         imem_addr   <= imem_addr_next;
         instr       <= instr_next;
         instr_valid <= instr_valid_next;
         pc_plus4    <= pc_plus4_next;
         flush       <= flush_next;
      end
   end

   always_comb begin
      state_next       = state;
      pc_next          = pc;
      imem_req_next    = imem_req;
      imem_addr_next   = imem_addr;
      instr_next       = instr;
      instr_valid_next = instr_valid;
      pc_plus4_next    = pc_plus4;
      flush_next       = 1'b0;

      // Jump wins over branch; beq and bne together always resolve taken.
      taken = (branch_eq & zero) | (branch_ne & ~zero);
      if (jump)
         redirect_pc = {pc_plus4[31:28], jump_target, 2'b00};
      else if (taken)
         redirect_pc = pc_plus4 + {branch_offset[29:0], 2'b00};
      else
         redirect_pc = pc_plus4;

      case (state)
         S_START: begin
            imem_req_next  = 1'b1;
            imem_addr_next = pc;
            state_next     = S_REQ;
         end
         S_REQ: begin
            if (imem_ready) begin
               instr_next       = imem_rdata;
               instr_valid_next = 1'b1;
               pc_plus4_next    = pc + 32'd4;
               imem_req_next    = 1'b0;
               state_next       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!stall) begin
               pc_next          = redirect_pc;
               instr_valid_next = 1'b0;
               imem_req_next    = 1'b1;
               imem_addr_next   = redirect_pc;
               flush_next       = jump | taken;
               state_next       = S_REQ;
            end
         end
         default: begin
            state_next = S_START;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed reset/stall/latency sequences, a redirect
// vector table, then randomized traffic against a transaction-level PC model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_eq = 1'b0;
   logic        branch_ne = 1'b0;
   logic        jump = 1'b0;
   logic        zero = 1'b0;
   logic [31:0] branch_offset = 32'h0;
   logic [25:0] jump_target = 26'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc_plus4;
   logic        flush;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
   endfunction

   // Memory returns junk unless it is presenting valid data.
   assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hBAD0_BAD0;

   fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump), .zero(zero),
      .branch_offset(branch_offset), .jump_target(jump_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
      .pc_plus4(pc_plus4), .flush(flush)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic clear_decode();
      branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b0; zero = 1'b0;
      branch_offset = 32'h0; jump_target = 26'h0;
   endtask

   task automatic wait_issue();
      int n = 0;
      while (instr_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL wait_issue: instr_valid=%b after %0d cycles, required 1", instr_valid, n);
      end
   endtask

   // Steer the PC to an arbitrary target using a taken beq (imem_ready held 1).
   task automatic goto(input logic [31:0] target);
      logic [31:0] delta;
      wait_issue();
      delta = (target - pc_plus4) >> 2;
      stall = 1'b0; branch_eq = 1'b1; zero = 1'b1; branch_offset = delta;
      @(negedge clk);
      clear_decode();
      wait_issue();
      chk("goto_pc_plus4", pc_plus4, target + 32'd4);
      chk("goto_instr", instr, mem_word(target));
   endtask

   // Reference next-PC from the architectural rules.
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic beq,
      input logic bne, input logic j, input logic z, input logic [31:0] off,
      input logic [25:0] jt);
      logic [31:0] seq;
      seq = pc + 32'd4;
      if (j) return {seq[31:28], jt, 2'b00};
      if ((beq && z) || (bne && !z)) return seq + (off << 2);
      return seq;
   endfunction

   typedef struct {
      logic [31:0] pc;
      logic        beq, bne, j, z;
      logic [31:0] off;
      logic [25:0] jt;
      logic [31:0] exp_next;
      logic        exp_flush;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [31:0] held_instr, held_p4, held_addr;
      logic [31:0] exp_pc, rnd, nxt;
      logic        exp_issue, exp_flush, taken;

      vecs[0] = '{32'h0000_0010, 1, 0, 0, 1, 32'hFFFF_FFFE, 26'h0, 32'h0000_000C, 1};
      vecs[1] = '{32'h0000_0010, 1, 0, 0, 0, 32'hFFFF_FFFE, 26'h0, 32'h0000_0014, 0};
      vecs[2] = '{32'h0000_0020, 0, 1, 0, 0, 32'h0000_0003, 26'h0, 32'h0000_0030, 1};
      vecs[3] = '{32'h4000_0040, 0, 0, 1, 0, 32'h0, 26'h000_0100, 32'h4000_0400, 1};
      vecs[4] = '{32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0000_0000, 0};
      vecs[5] = '{32'h0000_0100, 1, 1, 0, 0, 32'h0000_0001, 26'h0, 32'h0000_0108, 1};
      vecs[6] = '{32'h0000_0200, 1, 0, 1, 1, 32'h0000_0005, 26'h3, 32'h0000_000C, 1};
      vecs[7] = '{32'h0000_0300, 0, 1, 0, 1, 32'h0000_0007, 26'h0, 32'h0000_0304, 0};

      // Reset state
      @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc_plus4", pc_plus4, 32'h0);
      chk("rst_flush", 32'(flush), 32'd0);

      // Sequential fetch with zero-latency memory
      imem_ready = 1'b1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("seq_req", 32'(imem_req), 32'd1);
         chk("seq_addr", imem_addr, 32'(k * 4));
         chk("seq_valid_low", 32'(instr_valid), 32'd0);
         @(negedge clk);
         chk("seq_valid", 32'(instr_valid), 32'd1);
         chk("seq_instr", instr, mem_word(32'(k * 4)));
         chk("seq_flush", 32'(flush), 32'd0);
         $display("seq fetch addr=%h instr=%h", 32'(k * 4), instr);
      end

      // Stall for three cycles in issue
      held_instr = instr;
      held_p4 = pc_plus4;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_instr", instr, held_instr);
         chk("stall_no_req", 32'(imem_req), 32'd0);
      end
      stall = 1'b0;
      @(negedge clk);
      chk("stall_release_addr", imem_addr, held_p4);
      @(negedge clk);
      chk("stall_advance_once", pc_plus4, held_p4 + 32'd4);
      $display("stall released, next fetch addr=%h", held_p4);

      // Delayed memory response
      imem_ready = 1'b0;
      @(negedge clk);
      held_addr = imem_addr;
      chk("slow_req", 32'(imem_req), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("slow_req_hold", 32'(imem_req), 32'd1);
         chk("slow_addr_hold", imem_addr, held_addr);
         chk("slow_no_valid", 32'(instr_valid), 32'd0);
      end
      imem_ready = 1'b1;
      @(negedge clk);
      chk("slow_valid", 32'(instr_valid), 32'd1);
      chk("slow_instr", instr, mem_word(held_addr));
      $display("slow fetch addr=%h instr=%h", held_addr, instr);

      // Reset while a request is outstanding
      imem_ready = 1'b0;
      @(negedge clk);
      chk("mid_req", 32'(imem_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_req", 32'(imem_req), 32'd0);
      chk("async_rst_addr", imem_addr, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      chk("restart_addr", imem_addr, 32'h0);
      chk("restart_req", 32'(imem_req), 32'd1);
      @(negedge clk);
      chk("restart_instr", instr, mem_word(32'h0));
      $display("restart after reset at addr=%h", 32'h0);

      // Redirect vector table
      for (int v = 0; v < 8; v++) begin
         goto(vecs[v].pc);
         branch_eq = vecs[v].beq; branch_ne = vecs[v].bne; jump = vecs[v].j;
         zero = vecs[v].z; branch_offset = vecs[v].off; jump_target = vecs[v].jt;
         @(negedge clk);
         clear_decode();
         chk("vec_flush", 32'(flush), 32'(vecs[v].exp_flush));
         chk("vec_req", 32'(imem_req), 32'd1);
         chk("vec_next_addr", imem_addr, vecs[v].exp_next);
         @(negedge clk);
         chk("vec_flush_pulse", 32'(flush), 32'd0);
         chk("vec_next_p4", pc_plus4, vecs[v].exp_next + 32'd4);
         $display("vec %0d pc=%h next=%h flush=%0d", v, vecs[v].pc, imem_addr, vecs[v].exp_flush);
      end

      // Randomized traffic against the transaction model
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      imem_ready = 1'b0;
      @(negedge clk);
      exp_pc = 32'h0;
      exp_issue = 1'b0;
      exp_flush = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (c != 0) @(negedge clk);
         chk("rnd_flush", 32'(flush), 32'(exp_flush));
         rnd = $urandom;
         branch_eq = (rnd[1:0] == 2'd0);
         branch_ne = (rnd[3:2] == 2'd0);
         jump = (rnd[6:4] == 3'd0);
         zero = rnd[7];
         branch_offset = {{16{rnd[23]}}, rnd[23:8]};
         jump_target = 26'($urandom);
         if (exp_issue) begin
            chk("rnd_valid", 32'(instr_valid), 32'd1);
            chk("rnd_instr", instr, mem_word(exp_pc));
            chk("rnd_pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("rnd_req_idle", 32'(imem_req), 32'd0);
            stall = ($urandom_range(0, 3) == 0);
            imem_ready = $urandom_range(0, 1) == 1;
            if (!stall) begin
               nxt = model_next(exp_pc, branch_eq, branch_ne, jump, zero, branch_offset, jump_target);
               taken = jump || (branch_eq && zero) || (branch_ne && !zero);
               $display("rnd issue pc=%h next=%h redirect=%0d", exp_pc, nxt, taken);
               exp_pc = nxt;
               exp_flush = taken;
               exp_issue = 1'b0;
            end else begin
               exp_flush = 1'b0;
            end
         end else begin
            chk("rnd_valid_low", 32'(instr_valid), 32'd0);
            chk("rnd_req", 32'(imem_req), 32'd1);
            chk("rnd_addr", imem_addr, exp_pc);
            stall = 1'b0;
            imem_ready = ($urandom_range(0, 2) == 0);
            exp_flush = 1'b0;
            exp_issue = imem_ready;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
